// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: turns CPU memory read/write strobes into single-access KFSDRAM requests.
// Defining RAM_READ_BUFFER_EN adds a one-entry read buffer in front of the controller.
`timescale 1ns/1ps
module ram_bus_bridge #(
   parameter int ADDR_WIDTH     = 22,
   parameter int DATA_WIDTH     = 16,
   parameter int LANES          = DATA_WIDTH / 8,
   parameter int CTL_ADDR_WIDTH = 25,
   parameter int WAIT_WIDTH     = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     bus_address,
   input  logic [DATA_WIDTH-1:0]     bus_data_in,
   input  logic [LANES-1:0]          bus_byte_en,
   output logic [DATA_WIDTH-1:0]     bus_data_out,
   input  logic                      memory_read_n,
   input  logic                      memory_write_n,
   input  logic                      select_n,
   input  logic                      write_protect,
   input  logic                      no_command_state,
   input  logic                      wait_count_clk_en,
   input  logic [WAIT_WIDTH-1:0]     read_wait_cycle,
   input  logic [WAIT_WIDTH-1:0]     write_wait_cycle,
   output logic                      memory_access_ready,
   output logic                      initialized,
   output logic [CTL_ADDR_WIDTH-1:0] ctl_address,
   output logic [9:0]                ctl_access_num,
   output logic [15:0]               ctl_data_in,
   input  logic [15:0]               ctl_data_out,
   output logic                      ctl_write_request,
   output logic                      ctl_read_request,
   input  logic                      ctl_write_flag,
   input  logic                      ctl_read_flag,
   input  logic                      ctl_idle,
   input  logic                      ctl_refresh_mode,
   output logic                      ctl_enable_refresh,
   output logic [1:0]                ctl_dqm
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_BUSY = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_BUSY = 3'd4,
      ST_DONE    = 3'd5,
      ST_ABORT   = 3'd6
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic                  wr_cmd_s;
   logic                  rd_cmd_s;
   logic                  buf_hit_s;
   logic                  rd_hit_s;
   logic [DATA_WIDTH-1:0] buf_data_s;
   logic [DATA_WIDTH-1:0] data_r;
   logic [LANES-1:0]      byte_en_r;
   logic                  prev_no_command_state_r;
   logic                  access_ready_r;
   logic                  initialized_r;
   logic [WAIT_WIDTH-1:0] rd_cnt_r;
   logic [WAIT_WIDTH-1:0] wr_cnt_r;
   logic [DATA_WIDTH-1:0] bus_data_out_r;
   logic [1:0]            dqm_s;

   assign wr_cmd_s = ~select_n & ~memory_write_n & ~write_protect;
   assign rd_cmd_s = ~select_n & ~memory_read_n;
   assign rd_hit_s = (state_r == ST_IDLE) & ~wr_cmd_s & rd_cmd_s & buf_hit_s;

`ifdef RAM_READ_BUFFER_EN
   logic [ADDR_WIDTH-1:0] buf_tag_r;
   logic [LANES-1:0]      buf_be_r;
   logic [DATA_WIDTH-1:0] buf_data_r;
   logic                  buf_valid_r;
   logic                  wr_any_s;

   // Protected writes also count: the word may have changed behind the buffer's back.
   assign wr_any_s   = ~select_n & ~memory_write_n;
   assign buf_hit_s  = buf_valid_r & (buf_tag_r == bus_address) & (buf_be_r == bus_byte_en);
   assign buf_data_s = buf_data_r;

   // Read buffer: fill on controller read completion, drop on a write to the tagged word
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_tag_r   <= {ADDR_WIDTH{1'b0}};
         buf_be_r    <= {LANES{1'b0}};
         buf_data_r  <= {DATA_WIDTH{1'b0}};
         buf_valid_r <= 1'b0;
      end else if ((state_r == ST_RD_BUSY) && !ctl_read_flag) begin
         buf_tag_r   <= bus_address;
         buf_be_r    <= byte_en_r;
         buf_data_r  <= bus_data_out_r;
         buf_valid_r <= 1'b1;
      end else if (wr_any_s && (bus_address == buf_tag_r)) begin
         buf_valid_r <= 1'b0;
      end else begin
         buf_valid_r <= buf_valid_r;
      end
   end
`else
   assign buf_hit_s  = 1'b0;
   assign buf_data_s = {DATA_WIDTH{1'b0}};
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a flag edge outranks a dropped strobe
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (wr_cmd_s)                   state_next_s = ST_WR_REQ;
            else if (rd_cmd_s && buf_hit_s) state_next_s = ST_DONE;
            else if (rd_cmd_s)              state_next_s = ST_RD_REQ;
            else                            state_next_s = ST_IDLE;
         end
         ST_WR_REQ: begin
            if (ctl_write_flag)  state_next_s = ST_WR_BUSY;
            else if (!wr_cmd_s)  state_next_s = ST_ABORT;
            else                 state_next_s = ST_WR_REQ;
         end
         ST_WR_BUSY: begin
            if (!ctl_write_flag) state_next_s = ST_DONE;
            else if (!wr_cmd_s)  state_next_s = ST_ABORT;
            else                 state_next_s = ST_WR_BUSY;
         end
         ST_RD_REQ: begin
            if (ctl_read_flag)   state_next_s = ST_RD_BUSY;
            else if (!rd_cmd_s)  state_next_s = ST_ABORT;
            else                 state_next_s = ST_RD_REQ;
         end
         ST_RD_BUSY: begin
            if (!ctl_read_flag)  state_next_s = ST_DONE;
            else if (!rd_cmd_s)  state_next_s = ST_ABORT;
            else                 state_next_s = ST_RD_BUSY;
         end
         ST_DONE: begin
            if (!wr_cmd_s && !rd_cmd_s) state_next_s = ST_IDLE;
            else                        state_next_s = ST_DONE;
         end
         ST_ABORT: begin
            if (ctl_idle) state_next_s = ST_IDLE;
            else          state_next_s = ST_ABORT;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Unused upper lane of an 8-bit bus stays masked
   always_comb begin
      dqm_s = 2'b11;
      dqm_s[LANES-1:0] = ~byte_en_r;
   end

   // Controller request, address, data and mask outputs
   always_comb begin
      ctl_write_request = 1'b0;
      ctl_read_request  = 1'b0;
      ctl_address       = CTL_ADDR_WIDTH'(bus_address);
      ctl_data_in       = 16'(data_r);
      ctl_dqm           = dqm_s;
      case (state_r)
         ST_IDLE: begin
            if (wr_cmd_s)                    ctl_write_request = 1'b1;
            else if (rd_cmd_s && !buf_hit_s) ctl_read_request  = 1'b1;
            else                             ctl_read_request  = 1'b0;
         end
         ST_WR_REQ: ctl_write_request = 1'b1;
         ST_RD_REQ: ctl_read_request  = 1'b1;
         ST_DONE: begin
            ctl_address = {CTL_ADDR_WIDTH{1'b0}};
            ctl_data_in = 16'h0000;
         end
         ST_ABORT: begin
            ctl_address = {CTL_ADDR_WIDTH{1'b0}};
            ctl_data_in = 16'h0000;
            ctl_dqm     = 2'b11;
         end
         default: ctl_write_request = 1'b0;
      endcase
   end

   // Input latches and bus-idle history for the refresh edge detector
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_r                  <= {DATA_WIDTH{1'b0}};
         byte_en_r               <= {LANES{1'b1}};
         prev_no_command_state_r <= 1'b1;
      end else begin
         data_r                  <= bus_data_in;
         byte_en_r               <= bus_byte_en;
         prev_no_command_state_r <= no_command_state;
      end
   end

   // Bus-side ready tracking and sticky controller-initialised flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         access_ready_r <= 1'b0;
         initialized_r  <= 1'b0;
      end else begin
         if (state_r == ST_DONE)                                 access_ready_r <= 1'b1;
         else if (state_r == ST_IDLE)                            access_ready_r <= ctl_idle;
         else if ((wr_cmd_s || rd_cmd_s) && ctl_refresh_mode)    access_ready_r <= 1'b0;
         else                                                    access_ready_r <= access_ready_r;
         initialized_r <= initialized_r | ctl_idle;
      end
   end

   // Wait-state counters: reload while idle, count down to zero on tick enables
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_cnt_r <= {WAIT_WIDTH{1'b0}};
         wr_cnt_r <= {WAIT_WIDTH{1'b0}};
      end else begin
         if (!rd_cmd_s)
            rd_cnt_r <= read_wait_cycle;
         else if (wait_count_clk_en && (rd_cnt_r != {WAIT_WIDTH{1'b0}}))
            rd_cnt_r <= rd_cnt_r - WAIT_WIDTH'(1'b1);
         else
            rd_cnt_r <= rd_cnt_r;
         if (!wr_cmd_s)
            wr_cnt_r <= write_wait_cycle;
         else if (wait_count_clk_en && (wr_cnt_r != {WAIT_WIDTH{1'b0}}))
            wr_cnt_r <= wr_cnt_r - WAIT_WIDTH'(1'b1);
         else
            wr_cnt_r <= wr_cnt_r;
      end
   end

   // Read data capture: sample while the controller drives, hold for the strobe, else clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset)              bus_data_out_r <= {DATA_WIDTH{1'b0}};
      else if (ctl_read_flag) bus_data_out_r <= ctl_data_out[DATA_WIDTH-1:0];
      else if (rd_hit_s)      bus_data_out_r <= buf_data_s;
      else if (rd_cmd_s)      bus_data_out_r <= bus_data_out_r;
      else                    bus_data_out_r <= {DATA_WIDTH{1'b0}};
   end

   assign memory_access_ready = select_n | (memory_read_n & memory_write_n) |
                                (access_ready_r &
                                 ((rd_cnt_r == {WAIT_WIDTH{1'b0}}) | ~rd_cmd_s) &
                                 ((wr_cnt_r == {WAIT_WIDTH{1'b0}}) | ~wr_cmd_s));
   assign ctl_enable_refresh  = no_command_state & ~prev_no_command_state_r;
   assign ctl_access_num      = 10'd1;
   assign bus_data_out        = bus_data_out_r;
   assign initialized         = initialized_r;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Self-checking bench for ram_bus_bridge with a small KFSDRAM behavioural model.
// Covers the RAM_READ_BUFFER_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_ram_bus_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [21:0] bus_address;
   logic [15:0] bus_data_in;
   logic [1:0]  bus_byte_en;
   logic [15:0] bus_data_out;
   logic        memory_read_n, memory_write_n, select_n, write_protect;
   logic        no_command_state, wait_count_clk_en;
   logic [1:0]  read_wait_cycle, write_wait_cycle;
   logic        memory_access_ready, initialized;
   logic [24:0] ctl_address;
   logic [9:0]  ctl_access_num;
   logic [15:0] ctl_data_in, ctl_data_out;
   logic        ctl_write_request, ctl_read_request;
   logic        ctl_write_flag, ctl_read_flag, ctl_idle;
   logic        ctl_refresh_mode;
   logic        ctl_enable_refresh;
   logic [1:0]  ctl_dqm;

   ram_bus_bridge dut (
      .clock(clock), .reset(reset),
      .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_byte_en(bus_byte_en),
      .bus_data_out(bus_data_out),
      .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
      .select_n(select_n), .write_protect(write_protect),
      .no_command_state(no_command_state), .wait_count_clk_en(wait_count_clk_en),
      .read_wait_cycle(read_wait_cycle), .write_wait_cycle(write_wait_cycle),
      .memory_access_ready(memory_access_ready), .initialized(initialized),
      .ctl_address(ctl_address), .ctl_access_num(ctl_access_num),
      .ctl_data_in(ctl_data_in), .ctl_data_out(ctl_data_out),
      .ctl_write_request(ctl_write_request), .ctl_read_request(ctl_read_request),
      .ctl_write_flag(ctl_write_flag), .ctl_read_flag(ctl_read_flag),
      .ctl_idle(ctl_idle), .ctl_refresh_mode(ctl_refresh_mode),
      .ctl_enable_refresh(ctl_enable_refresh), .ctl_dqm(ctl_dqm)
   );

   always #5 clock = ~clock;

   // ---------------- controller model ----------------
   typedef struct packed {
      logic        wr;
      logic [24:0] addr;
      logic [15:0] data;
      logic [1:0]  dqm;
   } req_t;

   req_t        acc_log [0:63];
   int          acc_n;
   int          acc_delay;
   logic        m_busy, m_wr;
   int          m_cnt;
   logic [24:0] m_addr;
   logic [15:0] m_wdata;
   logic [1:0]  m_dqm;
   logic [15:0] mem [0:255];

   assign ctl_refresh_mode = 1'b0;
   assign ctl_idle       = ~m_busy & ~ctl_write_request & ~ctl_read_request;
   assign ctl_write_flag = m_busy & m_wr & (m_cnt <= 3);
   assign ctl_read_flag  = m_busy & ~m_wr & (m_cnt <= 3);
   assign ctl_data_out   = ctl_read_flag ? mem[m_addr[7:0]] : 16'h0000;

   // Accept one request when free, flag for three cycles, commit writes with masks
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0; m_wr <= 1'b0; m_cnt <= 0; acc_n <= 0;
         m_addr <= 25'h0; m_wdata <= 16'h0; m_dqm <= 2'b00;
      end else if (!m_busy) begin
         if (ctl_write_request || ctl_read_request) begin
            m_busy  <= 1'b1;
            m_wr    <= ctl_write_request;
            m_cnt   <= 3 + acc_delay;
            m_addr  <= ctl_address;
            m_wdata <= ctl_data_in;
            m_dqm   <= ctl_dqm;
            if (acc_n < 64)
               acc_log[acc_n] <= '{ctl_write_request, ctl_address, ctl_data_in, ctl_dqm};
            acc_n <= acc_n + 1;
         end
      end else begin
         if (m_cnt == 1) begin
            m_busy <= 1'b0;
            if (m_wr)
               mem[m_addr[7:0]] <= {m_dqm[1] ? mem[m_addr[7:0]][15:8] : m_wdata[15:8],
                                    m_dqm[0] ? mem[m_addr[7:0]][7:0]  : m_wdata[7:0]};
         end
         m_cnt <= m_cnt - 1;
      end
   end

   // ---------------- checking ----------------
   typedef struct {
      logic        wr;
      logic        wp;
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
      logic        req;
      logic [15:0] rdata;
   } vec_t;

   vec_t        vecs [0:10];
   req_t        exp_q [$];
   logic [15:0] rd_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          rd_idx = 0;
   int          exp_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_req(input logic wr, input logic [21:0] addr, input logic [15:0] data,
                           input logic [1:0] be);
      exp_q.push_back('{wr, 25'(addr), wr ? data : 16'h0000, ~be});
      exp_total++;
   endtask

   task automatic drain_reqs();
      req_t got;
      req_t e;
      while (rd_idx < acc_n) begin
         got = acc_log[rd_idx];
         rd_idx++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_request: got wr=%0b addr=%0h, expected none", got.wr, got.addr);
         end else begin
            e = exp_q.pop_front();
            check("req_wr", 32'(got.wr), 32'(e.wr));
            check("req_addr", 32'(got.addr), 32'(e.addr));
            check("req_dqm", 32'(got.dqm), 32'(e.dqm));
            if (e.wr) check("req_data", 32'(got.data), 32'(e.data));
         end
      end
      check("missing_request", exp_q.size(), 0);
   endtask

   task automatic bus_access(input vec_t v);
      int          cyc;
      logic        flag_seen;
      logic [15:0] exp_rd;
      @(negedge clock);
      bus_address = v.addr; bus_data_in = v.data; bus_byte_en = v.be;
      write_protect = v.wp; select_n = 1'b0;
      if (v.req) push_req(v.wr, v.addr, v.data, v.be);
      @(negedge clock);
      if (v.wr) memory_write_n = 1'b0;
      else begin
         memory_read_n = 1'b0;
         rd_q.push_back(v.rdata);
      end
      #1;
      if (v.wp) check("wp_ready_first", 32'(memory_access_ready), 1);
      cyc = 0;
      flag_seen = 1'b0;
      @(negedge clock);
      while (!memory_access_ready && cyc < 60) begin
         if (ctl_write_flag || ctl_read_flag) flag_seen = 1'b1;
         @(negedge clock);
         cyc++;
      end
      check("ready_timeout", 32'(cyc < 60), 1);
      check("flag_before_ready", 32'(flag_seen), 32'(v.req));
      check("flag_low_at_ready", 32'(ctl_write_flag | ctl_read_flag), 0);
      if (!v.wr) begin
         exp_rd = rd_q.pop_front();
         check("read_data", 32'(bus_data_out), 32'(exp_rd));
      end
      if (v.wp) begin
         repeat (3) @(negedge clock);
         check("wp_ready_hold", 32'(memory_access_ready), 1);
      end
      memory_write_n = 1'b1;
      memory_read_n  = 1'b1;
      @(negedge clock);
      if (!v.wr) check("read_drop", 32'(bus_data_out), 0);
      select_n = 1'b1;
      write_protect = 1'b0;
      @(negedge clock);
      drain_reqs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      int   cyc;
      vec_t v;
      select_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1; write_protect = 1'b0;
      no_command_state = 1'b0; wait_count_clk_en = 1'b0;
      read_wait_cycle = 2'd0; write_wait_cycle = 2'd0;
      bus_address = 22'h0; bus_data_in = 16'h0; bus_byte_en = 2'b11; acc_delay = 1;

      //          wr    wp    addr        data      be     req   rdata
      vecs[0]  = '{1'b1, 1'b0, 22'h001234, 16'hA55A, 2'b11, 1'b1, 16'h0000};
      vecs[1]  = '{1'b0, 1'b0, 22'h001234, 16'h0000, 2'b11, 1'b1, 16'hA55A};
      vecs[2]  = '{1'b1, 1'b0, 22'h001234, 16'hFF00, 2'b10, 1'b1, 16'h0000};
      vecs[3]  = '{1'b0, 1'b0, 22'h001234, 16'h0000, 2'b11, 1'b1, 16'hFF5A};
      vecs[4]  = '{1'b1, 1'b1, 22'h001234, 16'h1234, 2'b11, 1'b0, 16'h0000};
      vecs[5]  = '{1'b0, 1'b0, 22'h001234, 16'h0000, 2'b11, 1'b1, 16'hFF5A};
      vecs[6]  = '{1'b1, 1'b0, 22'h3FFFFF, 16'h8001, 2'b11, 1'b1, 16'h0000};
      vecs[7]  = '{1'b0, 1'b0, 22'h3FFFFF, 16'h0000, 2'b11, 1'b1, 16'h8001};
      vecs[8]  = '{1'b1, 1'b0, 22'h000000, 16'hC3C3, 2'b11, 1'b1, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 22'h000000, 16'h0077, 2'b01, 1'b1, 16'h0000};
      vecs[10] = '{1'b0, 1'b0, 22'h000000, 16'h0000, 2'b11, 1'b1, 16'hC377};

      repeat (2) @(negedge clock);
      check("rst_data_out", 32'(bus_data_out), 0);
      check("rst_wr_req", 32'(ctl_write_request), 0);
      check("rst_rd_req", 32'(ctl_read_request), 0);
      check("rst_dqm", 32'(ctl_dqm), 0);
      check("rst_initialized", 32'(initialized), 0);
      check("rst_refresh", 32'(ctl_enable_refresh), 0);
      check("rst_ready_unselected", 32'(memory_access_ready), 1);
      reset = 1'b0;
      @(negedge clock);
      check("initialized_set", 32'(initialized), 1);
      check("access_num", 32'(ctl_access_num), 1);

      for (int i = 0; i < 11; i++) bus_access(vecs[i]);

      // wait states: three ticks, one every fourth cycle, first after cycle 3
      @(negedge clock);
      read_wait_cycle = 2'd3; bus_address = 22'h001234; bus_byte_en = 2'b11; select_n = 1'b0;
      push_req(1'b0, 22'h001234, 16'h0000, 2'b11);
      @(negedge clock);
      memory_read_n = 1'b0;
      cyc = 0;
      while (cyc < 60) begin
         wait_count_clk_en = ((cyc % 4) == 3);
         @(negedge clock);
         cyc++;
         if (memory_access_ready) break;
      end
      wait_count_clk_en = 1'b0;
      check("wait_ready_delay", 32'((cyc >= 12) && (cyc < 60)), 1);
      check("wait_read_data", 32'(bus_data_out), 32'h0000FF5A);
      memory_read_n = 1'b1;
      @(negedge clock);
      select_n = 1'b1; read_wait_cycle = 2'd0;
      @(negedge clock);
      drain_reqs();

      // strobe removed while the request is still pending
      acc_delay = 4;
      @(negedge clock);
      bus_address = 22'h000055; bus_byte_en = 2'b11; select_n = 1'b0;
      push_req(1'b0, 22'h000055, 16'h0000, 2'b11);
      @(negedge clock);
      memory_read_n = 1'b0;
      @(negedge clock);
      memory_read_n = 1'b1;
      @(negedge clock);
      check("abort_dqm", 32'(ctl_dqm), 32'h3);
      check("abort_no_rd_req", 32'(ctl_read_request), 0);
      check("abort_no_wr_req", 32'(ctl_write_request), 0);
      cyc = 0;
      while (!ctl_idle && cyc < 60) begin
         @(negedge clock);
         cyc++;
      end
      check("abort_idle_timeout", 32'(cyc < 60), 1);
      check("abort_dqm_until_idle", 32'(ctl_dqm), 32'h3);
      @(negedge clock);
      check("abort_back_to_idle", 32'(ctl_dqm), 0);
      select_n = 1'b1; acc_delay = 1;
      @(negedge clock);
      drain_reqs();

      // refresh pulse only on the rising edge of bus idle
      @(negedge clock);
      no_command_state = 1'b1;
      #1 check("refresh_pulse", 32'(ctl_enable_refresh), 1);
      @(negedge clock);
      check("refresh_single", 32'(ctl_enable_refresh), 0);
      no_command_state = 1'b0;
      #1 check("refresh_fall", 32'(ctl_enable_refresh), 0);

      // repeated read of the last controller read
`ifdef RAM_READ_BUFFER_EN
      v = '{1'b0, 1'b0, 22'h001234, 16'h0000, 2'b11, 1'b0, 16'hFF5A};
`else
      v = '{1'b0, 1'b0, 22'h001234, 16'h0000, 2'b11, 1'b1, 16'hFF5A};
`endif
      bus_access(v);

      check("total_requests", acc_n, exp_total);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_bus_bridge.md
Name: ram_bus_bridge

Overview:
- Parametrised CPU-bus to SDRAM-controller bridge; successor to the fixed 8-bit XT RAM front-end.
- Converts the active-low memory read/write strobes into single-access requests to the KFSDRAM controller.
- Supports configurable data width with byte lanes, configurable wait-state counter width, and generates refresh pulses at bus-idle edges.
- Sits between the bus arbiter / address decoder and KFSDRAM; region decode, EMS and BIOS address mapping stay upstream.

Parameters:
- ADDR_WIDTH, 22, width of the mapped bus address fed in (already includes EMS/BIOS mapping bits).
- DATA_WIDTH, 16, bus data width; legal values 8 or 16.
- LANES, DATA_WIDTH/8, number of byte lanes.
- CTL_ADDR_WIDTH, 25, controller address width; the bus address is zero-extended into it.
- WAIT_WIDTH, 2, width of the read/write wait-state counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_address  in  ADDR_WIDTH  mapped access address
- bus_data_in  in  DATA_WIDTH  write data
- bus_byte_en  in  LANES  active-high byte enables
- bus_data_out  out  DATA_WIDTH  read data
- memory_read_n  in  1  read strobe
- memory_write_n  in  1  write strobe
- select_n  in  1  region selected (active-low)
- write_protect  in  1  suppresses writes to the current address
- no_command_state  in  1  bus-idle indicator, used for refresh
- wait_count_clk_en  in  1  wait-counter tick enable
- read_wait_cycle  in  WAIT_WIDTH  extra read wait ticks
- write_wait_cycle  in  WAIT_WIDTH  extra write wait ticks
- memory_access_ready  out  1  bus ready
- initialized  out  1  sticky high after the first controller idle
- ctl_address  out  CTL_ADDR_WIDTH  controller address
- ctl_access_num  out  10  burst length, constant 1
- ctl_data_in  out  16  controller write data
- ctl_data_out  in  16  controller read data
- ctl_write_request, ctl_read_request  out  1  controller requests
- ctl_write_flag, ctl_read_flag, ctl_idle, ctl_refresh_mode  in  1  controller status
- ctl_enable_refresh  out  1  refresh pulse
- ctl_dqm  out  2  byte masks, active-high

Behaviour:
- Command decode:
  - wr_cmd = ~select_n & ~memory_write_n & ~write_protect.
  - rd_cmd = ~select_n & ~memory_read_n.
  - If both are asserted, wr_cmd wins.
- Input registers: bus_data_in and bus_byte_en are registered every cycle (one-cycle latch). bus_address is combinational into ctl_address.
- State machine (registered next-state logic), states:
  - IDLE: wr_cmd -> WR_REQ; rd_cmd -> RD_REQ. The request output is asserted combinationally in IDLE when the command is present.
  - WR_REQ: ctl_write_request=1; on ctl_write_flag -> WR_BUSY.
  - WR_BUSY: on ~ctl_write_flag -> DONE.
  - RD_REQ: ctl_read_request=1; on ctl_read_flag -> RD_BUSY.
  - RD_BUSY: on ~ctl_read_flag -> DONE.
  - Command loss in WR_*/RD_*: if the strobe drops -> ABORT. A flag transition in the same cycle takes priority over ABORT.
  - DONE: stays until both commands are low -> IDLE.
  - ABORT: ctl_dqm=2'b11, no requests; on ctl_idle -> IDLE.
- Byte masks:
  - ctl_dqm = ~latched byte_en, zero-extended into 2 bits; when DATA_WIDTH=8, ctl_dqm[1]=1.
  - Write data: ctl_data_in = latched data, zero-extended.
  - In DONE/ABORT: ctl_address=0, ctl_data_in=0.
- Read data capture:
  - bus_data_out <= ctl_data_out[DATA_WIDTH-1:0] while ctl_read_flag.
  - Holds its value while rd_cmd is asserted.
  - Forced to 0 otherwise.
- Refresh: ctl_enable_refresh = no_command_state & ~prev_no_command_state, where prev_no_command_state is a register.
- access_ready register, priority order:
  1. DONE -> 1.
  2. IDLE -> ctl_idle.
  3. Command active & ctl_refresh_mode -> 0.
  4. Otherwise hold.
- Wait counters:
  - Each counter reloads from its wait-cycle input while its command is inactive.
  - Decrements on wait_count_clk_en while nonzero; saturates at 0.
- Ready output:
  - memory_access_ready = 1 when select_n=1 or both strobes are high.
  - Otherwise: access_ready & (rd_cnt==0 | ~rd_cmd) & (wr_cnt==0 | ~wr_cmd).
- Write-protected write: no request is issued; ready follows access_ready, so the bus is not stalled.
- initialized: sticky; set on the first ctl_idle.
- Reset values: state=IDLE, all requests 0, ctl_dqm=0, bus_data_out=0, access_ready=0, counters=0, initialized=0, ctl_enable_refresh=0.
- Reset asserted mid-access: the bridge returns to IDLE immediately. The controller resets on the same reset.

Optional Feature:
- Macro RAM_READ_BUFFER_EN.
- When defined:
  - Adds a one-entry read buffer: tag = address, data, valid.
  - A read in IDLE that hits a valid tag with the same byte_en skips the controller: data is presented on the next cycle, state goes straight to DONE.
  - The buffer fills on every completed controller read.
  - Any write (including a protected one) to the same word address clears valid; reset clears valid.
- When undefined: every read goes to the controller. The logic is absent.

Test Plan:
- Write 0xA55A, byte_en=2'b11, addr 0x01234 -> one ctl_write_request, ctl_dqm=00, ctl_data_in=0xA55A; ready after the flag falls.
- Read back addr 0x01234 -> bus_data_out=0xA55A; it drops to 0 one cycle after memory_read_n rises.
- Byte write byte_en=2'b10, data 0xFF00 -> ctl_dqm=2'b01; a subsequent read returns 0xFF5A.
- write_protect=1 write -> no ctl_write_request; memory_access_ready stays 1.
- read_wait_cycle=3, wait_count_clk_en every 4th cycle -> ready delayed by at least 12 cycles after the read starts.
- Strobe removed in RD_REQ -> ABORT with ctl_dqm=11; IDLE on ctl_idle. With RAM_READ_BUFFER_EN, a repeated read of 0x01234 issues no ctl_read_request.
